// File: rtl/auth_seq_ctrl.sv
// auth_seq_ctrl: UART-driven power authorisation FSM (GO/PIN/STOP) with rider-off debounce and lockout
//   clk           rising-edge system clock
//   rst           asynchronous active-high reset
//   i_rx_rdy      UART receiver holds a valid byte
//   i_rx_data     received byte
//   i_rider_off   raw rider-absent flag
//   o_clr_rx_rdy  one-cycle consume strobe to the UART
//   o_pwr_up      motor power enable (PWR1/PWR2)
//   o_auth_fail   one-cycle pulse per failed PIN attempt
//   o_locked      lockout active
//   o_pin_busy    PIN entry in progress
module auth_seq_ctrl #(
    parameter logic [7:0]  GO_CODE   = 8'h47,
    parameter logic [7:0]  STOP_CODE = 8'h53,
    parameter int          PIN_LEN   = 0,
    parameter logic [31:0] PIN       = 32'h0000_0000,
    parameter logic [23:0] PIN_TMO   = 24'd1_000_000,
    parameter int          MAX_FAIL  = 3,
    parameter logic [15:0] OFF_DLY   = 16'd1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_rx_rdy,
    input  logic [7:0] i_rx_data,
    input  logic       i_rider_off,
    output logic       o_clr_rx_rdy,
    output logic       o_pwr_up,
    output logic       o_auth_fail,
    output logic       o_locked,
    output logic       o_pin_busy
);
    typedef enum logic [2:0] {S_OFF, S_PIN, S_PWR1, S_PWR2, S_LOCK} state_t;

    localparam logic [1:0] LAST = (PIN_LEN == 0) ? 2'd0 : 2'(PIN_LEN - 1);
    localparam logic [3:0] MAXF = 4'(MAX_FAIL);

    state_t      r_state, w_next;
    logic        r_clr, r_off_q, w_off_q_n, w_fail, w_afail;
    logic [7:0]  r_data, w_exp;
    logic [1:0]  r_idx, w_idx_n;
    logic [23:0] r_tmr, w_tmr_n;
    logic [3:0]  r_fail, w_fail_n, w_fail_inc;
    logic [15:0] r_off_cnt, w_off_cnt_n;

    // r_clr high marks the cycle in which the latched byte r_data is acted on
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_clr     <= 1'b0;
            r_data    <= '0;
            r_off_cnt <= '0;
            r_off_q   <= 1'b0;
        end else begin
            r_clr     <= i_rx_rdy & ~r_clr;
            r_data    <= (i_rx_rdy & ~r_clr) ? i_rx_data : r_data;
            r_off_cnt <= w_off_cnt_n;
            r_off_q   <= w_off_q_n;
        end
    end

    always_comb begin
        w_off_cnt_n = ~i_rider_off ? 16'd0 : (r_off_cnt == OFF_DLY) ? r_off_cnt : r_off_cnt + 16'd1;
        w_off_q_n   = (OFF_DLY == 16'd0) ? i_rider_off : (w_off_cnt_n == OFF_DLY);
    end

    // PIN bytes are sent most-significant first within the PIN_LEN-byte field
    assign w_exp      = 8'(PIN >> {LAST - r_idx, 3'b000});
    assign w_fail_inc = (r_fail == MAXF) ? r_fail : r_fail + 4'd1;

    always_comb begin
        w_next   = r_state;
        w_idx_n  = r_idx;
        w_tmr_n  = r_tmr;
        w_fail_n = r_fail;
        w_fail   = 1'b0;
        w_afail  = 1'b0;
        case (r_state)
            S_OFF: begin
                if (r_clr && r_data == GO_CODE) begin
                    w_next  = (PIN_LEN == 0) ? S_PWR1 : S_PIN;
                    w_idx_n = '0;
                    w_tmr_n = '0;
                end
            end
            S_PIN: begin
                if (r_clr) begin
                    if (r_data != w_exp) begin
                        w_fail = 1'b1;
                    end else if (r_idx == LAST) begin
                        w_next   = S_PWR1;
                        w_fail_n = '0;
                    end else begin
                        w_idx_n = r_idx + 2'd1;
                        w_tmr_n = '0;
                    end
                end else if (r_tmr >= PIN_TMO) begin
                    w_fail = 1'b1;
                end else begin
                    w_tmr_n = (r_tmr == '1) ? r_tmr : r_tmr + 24'd1;
                end
            end
            S_PWR1: begin
                if (r_clr && r_data == STOP_CODE) w_next = r_off_q ? S_OFF : S_PWR2;
            end
            S_PWR2: begin
                if (r_clr && r_data == GO_CODE) w_next = S_PWR1;
                else if (r_off_q) w_next = S_OFF;
            end
            S_LOCK: w_next = S_LOCK;
            default: w_next = S_OFF;
        endcase
        if (w_fail) begin
            w_fail_n = w_fail_inc;
            w_afail  = 1'b1;
            w_next   = (w_fail_inc == MAXF) ? S_LOCK : S_OFF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_OFF;
            r_idx       <= '0;
            r_tmr       <= '0;
            r_fail      <= '0;
            o_pwr_up    <= 1'b0;
            o_auth_fail <= 1'b0;
            o_locked    <= 1'b0;
            o_pin_busy  <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_idx       <= w_idx_n;
            r_tmr       <= w_tmr_n;
            r_fail      <= w_fail_n;
            o_pwr_up    <= (w_next == S_PWR1) || (w_next == S_PWR2);
            o_auth_fail <= w_afail;
            o_locked    <= (w_next == S_LOCK);
            o_pin_busy  <= (w_next == S_PIN);
        end
    end

    assign o_clr_rx_rdy = r_clr;
endmodule

// File: doc/auth_seq_ctrl.md
AUTH_SEQ_CTRL -- requirements
Module: auth_seq_ctrl

Interface
REQ-001 Parameter GO_CODE, 8'h47, byte that requests power-up ('G').
REQ-002 Parameter STOP_CODE, 8'h53, byte that requests power-down ('S').
REQ-003 Parameter PIN_LEN, 0, number of PIN bytes required after GO; legal 0..4; 0 disables PIN entry.
REQ-004 Parameter PIN, 32'h0000_0000, expected PIN; byte k (k=0 first) is PIN[8*(PIN_LEN-k)-1 -: 8].
REQ-005 Parameter PIN_TMO, 24'd1_000_000, maximum clocks between PIN bytes.
REQ-006 Parameter MAX_FAIL, 3, failed attempts before lockout; legal 1..15.
REQ-007 Parameter OFF_DLY, 16'd1024, consecutive clocks rider_off must stay high to count as off; 0 uses raw rider_off.
REQ-008 clk  input  1  system clock; all logic is on the rising edge.
REQ-009 rst  input  1  reset; asynchronous, active-high.
REQ-010 rx_rdy  input  1  UART receiver holds a valid byte.
REQ-011 rx_data  input  8  received byte.
REQ-012 rider_off  input  1  raw rider-absent flag from steering/load-cell logic.
REQ-013 clr_rx_rdy  output  1  one-cycle consume strobe to the UART.
REQ-014 pwr_up  output  1  motor power enable.
REQ-015 auth_fail  output  1  one-cycle pulse per failed attempt.
REQ-016 locked  output  1  lockout active.
REQ-017 pin_busy  output  1  PIN entry in progress.

Function
REQ-018 Block is a registered FSM with states OFF, PIN, PWR1, PWR2, LOCK; all outputs are registered.
REQ-019 Any rx_rdy high with clr_rx_rdy low is consumed: clr_rx_rdy pulses in the next cycle, and the byte is acted on in that same cycle. Every byte is consumed in every state, including LOCK.
REQ-020 Debounce: a counter increments while rider_off=1 and clears while rider_off=0; off_q=1 when count reaches OFF_DLY, and the counter saturates there; off_q=rider_off when OFF_DLY=0.
REQ-021 OFF transitions: GO_CODE goes to PWR1 if PIN_LEN=0, otherwise to PIN; all other bytes are ignored.
REQ-022 PIN: bytes are compared in order against PIN; a match on the final byte goes to PWR1 and clears fail_cnt.
REQ-023 PIN: the first mismatching byte goes to OFF, pulses auth_fail, and increments fail_cnt.
REQ-024 PIN: no byte within PIN_TMO clocks of PIN entry or of the last byte goes to OFF, pulses auth_fail, and increments fail_cnt.
REQ-025 PIN: the index and timer reset on every PIN entry.
REQ-026 A failure that makes fail_cnt equal to MAX_FAIL goes to LOCK instead of OFF; the auth_fail pulse is still issued.
REQ-027 PWR1 transitions: STOP_CODE with off_q=1 goes to OFF; STOP_CODE with off_q=0 goes to PWR2; GO_CODE is ignored.
REQ-028 PWR2 transitions: GO_CODE goes to PWR1, and takes priority over a simultaneous off_q=1; otherwise off_q=1 goes to OFF.
REQ-029 pwr_up=1 exactly in PWR1 and PWR2.
REQ-030 pin_busy=1 exactly in PIN.
REQ-031 locked=1 exactly in LOCK.
REQ-032 LOCK is left only by rst.
REQ-033 Latency: with PIN_LEN=0, pwr_up rises 2 clocks after rx_rdy with GO (1 clock to consume, 1 to update state).
REQ-034 Latency: pwr_up falls 2 clocks after the qualifying STOP or off_q event.
REQ-035 fail_cnt is 4 bits, never wraps, and saturates at MAX_FAIL.
REQ-036 The PIN timer saturates and does not wrap.

Reset
REQ-037 rst=1 asynchronously forces state OFF, pwr_up=0, clr_rx_rdy=0, auth_fail=0, locked=0 and pin_busy=0.
REQ-038 rst=1 also clears fail_cnt, the PIN index, the PIN timer and the debounce counter.
REQ-039 Reset mid-PIN or mid-LOCK returns to OFF with no auth_fail pulse.
REQ-040 The first byte after reset release is processed normally.

Verification
REQ-041 Scenario 1 (PIN_LEN=0): send 8'h47 -> pwr_up=1 two clocks after rx_rdy; clr_rx_rdy is a single pulse.
REQ-042 Scenario 2 (PIN_LEN=0): power up, rider_off=0, send 8'h53 -> pwr_up stays 1 in PWR2.
REQ-043 Scenario 2, continued: then rider_off=1 held for 1024 clocks -> pwr_up=0 by clock 1026; a rider_off glitch of 500 clocks leaves pwr_up=1.
REQ-044 Scenario 3 (PIN_LEN=2, PIN=16'h3142): send 8'h47, 8'h31, 8'h42 -> pin_busy high between bytes, then pwr_up=1 and auth_fail never pulses.
REQ-045 Scenario 4 (PIN_LEN=2, MAX_FAIL=3): three attempts of 8'h47, 8'h31, 8'h00 -> three auth_fail pulses and locked=1; a later correct sequence leaves pwr_up=0; rst clears locked.
REQ-046 Scenario 5 (PIN_TMO=1000): send 8'h47 then no byte for 1001 clocks -> auth_fail pulse, state OFF, pin_busy=0.
REQ-047 Scenario 6: in PWR2, 8'h47 arrives in the same cycle as off_q=1 -> PWR1, pwr_up stays 1; rst asserted mid-PWR1 -> pwr_up=0 immediately, with no clock edge needed.
